button_event_scheduler: RTL

//  Turns debounced button levels (NBTN buttons, active-high "pressed") into discrete press events.

---
 rtl/button_event_scheduler_pkg.sv | 9 +
 rtl/button_event_scheduler_timer.sv | 71 +++++++
 rtl/button_event_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/button_event_scheduler_pkg.sv
// Shared constants for the button event scheduler: event kind encoding and
// the width of the button index carried on the event stream.
package button_evt_pkg;

    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;
    localparam int   EVT_BTN_W = 3;

endpackage

// File: rtl/button_event_scheduler_timer.sv
// Per-button press classifier: hold timer, edge detection and a one-deep
// pending event slot with a sticky overrun flag.
module btn_press_timer
    import button_evt_pkg::*;
#(
    parameter int LONG_CYC = 16,
    parameter int CNT_W    = $clog2(LONG_CYC + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic grant_i,
    input  logic clr_overrun_i,
    output logic slot_full_o,
    output logic slot_kind_o,
    output logic overrun_o
);

    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYC - 1);

    logic             prev_q;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             slot_full_q, slot_full_d;
    logic             slot_kind_q, slot_kind_d;
    logic             overrun_q, overrun_d;
    logic             long_evt, short_evt, new_evt, drop;

    always_comb begin
        long_evt  = btn_i && (timer_q == LONG_M1);
        short_evt = !btn_i && prev_q && (timer_q < LONG_MAX);
        new_evt   = long_evt || short_evt;
        // A slot being drained this cycle can accept the new event.
        drop      = new_evt && slot_full_q && !grant_i;

        timer_d = '0;
        if (btn_i) begin
            timer_d = (timer_q == LONG_MAX) ? timer_q : timer_q + 1'b1;
        end

        slot_full_d = slot_full_q && !grant_i;
        slot_kind_d = slot_kind_q;
        if (new_evt && !drop) begin
            slot_full_d = 1'b1;
            slot_kind_d = long_evt ? EVT_LONG : EVT_SHORT;
        end

        overrun_d = drop ? 1'b1 : (clr_overrun_i ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q      <= 1'b0;
            timer_q     <= '0;
            slot_full_q <= 1'b0;
            slot_kind_q <= EVT_SHORT;
            overrun_q   <= 1'b0;
        end else begin
            prev_q      <= btn_i;
            timer_q     <= timer_d;
            slot_full_q <= slot_full_d;
            slot_kind_q <= slot_kind_d;
            overrun_q   <= overrun_d;
        end
    end

    assign slot_full_o = slot_full_q;
    assign slot_kind_o = slot_kind_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/button_event_scheduler.sv
// Collects SHORT/LONG press events from all buttons and serialises them onto
// one valid/ready stream using a round-robin grant over the pending slots.
module button_event_scheduler
    import button_evt_pkg::*;
#(
    parameter int NBTN     = 4,
    parameter int LONG_CYC = 12_000_000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NBTN-1:0]      btn_state,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [EVT_BTN_W-1:0] evt_btn,
    output logic                 evt_kind,
    output logic [NBTN-1:0]      overrun,
    input  logic                 clr_overrun
);

    localparam int CNT_W = $clog2(LONG_CYC + 1);
    localparam int PTR_W = $clog2(NBTN);

    logic [NBTN-1:0]      slot_full, slot_kind, grant_vec;
    logic [PTR_W-1:0]     rr_q, rr_d, grant_idx;
    logic                 any_full, load;
    logic                 evt_valid_q, evt_valid_d;
    logic [EVT_BTN_W-1:0] evt_btn_q, evt_btn_d;
    logic                 evt_kind_q, evt_kind_d;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_press_timer #(
            .LONG_CYC(LONG_CYC),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clk_i        (CLK),
            .rst_ni       (RST_N),
            .btn_i        (btn_state[i]),
            .grant_i      (grant_vec[i]),
            .clr_overrun_i(clr_overrun),
            .slot_full_o  (slot_full[i]),
            .slot_kind_o  (slot_kind[i]),
            .overrun_o    (overrun[i])
        );
    end

    // First full slot at or above the pointer, wrapping past the top button.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        any_full  = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NBTN; k++) begin
            idx  = (int'(rr_q) + k) % NBTN;
            cand = PTR_W'(idx);
            if (!any_full && slot_full[cand]) begin
                any_full  = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        load        = (!evt_valid_q || evt_ready) && any_full;
        grant_vec   = load ? (NBTN'(1) << grant_idx) : '0;
        evt_valid_d = evt_valid_q;
        evt_btn_d   = evt_btn_q;
        evt_kind_d  = evt_kind_q;
        rr_d        = rr_q;
        if (load) begin
            evt_valid_d = 1'b1;
            evt_btn_d   = EVT_BTN_W'(grant_idx);
            evt_kind_d  = slot_kind[grant_idx];
            rr_d        = (grant_idx == PTR_W'(NBTN - 1)) ? '0 : grant_idx + 1'b1;
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_valid_q <= 1'b0;
            evt_btn_q   <= '0;
            evt_kind_q  <= EVT_SHORT;
            rr_q        <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_btn_q   <= evt_btn_d;
            evt_kind_q  <= evt_kind_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_btn   = evt_btn_q;
    assign evt_kind  = evt_kind_q;

endmodule
